// File: rtl/drac_pkg.sv
// Shared types for the Lagarto committed-store buffer: entry layout, drain FSM states
// and the byte-lane merge used when stores coalesce into the tail entry.
package drac_pkg;

  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 26;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] index;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic [63:0]                   wdata;
    logic [7:0]                    be;
    logic [1:0]                    size;
  } stb_entry_t;

  typedef enum logic [1:0] {
    STB_IDLE,
    STB_REQ,
    STB_TAG
  } stb_state_t;

  function automatic logic [63:0] stb_merge_bytes(input logic [63:0] old_d,
                                                  input logic [63:0] new_d,
                                                  input logic [7:0]  be);
    logic [63:0] r;
    r = old_d;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/lagarto_stb_word_match.sv
// Per-entry comparator: same 64-bit word (tag + index above the byte offset) with
// at least one overlapping byte lane, qualified by an enable.
module lagarto_stb_word_match #(
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 26
) (
  input  logic               en,
  input  logic [INDEX_W-1:3] word_a,
  input  logic [TAG_W-1:0]   tag_a,
  input  logic [7:0]         be_a,
  input  logic [INDEX_W-1:3] word_b,
  input  logic [TAG_W-1:0]   tag_b,
  input  logic [7:0]         be_b,
  output logic               hit
);

  assign hit = en & (tag_a == tag_b) & (word_a == word_b) & (|(be_a & be_b));

endmodule

// File: rtl/lagarto_store_buffer.sv
// In-order committed-store buffer draining into the L1 dcache (index phase, then tag phase).
// Optional tail coalescing of same-word stores is enabled by defining LAGARTO_STB_COALESCE_EN.
module lagarto_store_buffer
  import drac_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INDEX_W = DCACHE_INDEX_WIDTH,
  parameter int TAG_W   = DCACHE_TAG_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [INDEX_W-1:0]         st_index_i,
  input  logic [TAG_W-1:0]           st_tag_i,
  input  logic [63:0]                st_wdata_i,
  input  logic [7:0]                 st_be_i,
  input  logic [1:0]                 st_size_i,
  input  logic                       ld_chk_valid_i,
  input  logic [INDEX_W-1:0]         ld_chk_index_i,
  input  logic [TAG_W-1:0]           ld_chk_tag_i,
  input  logic [7:0]                 ld_chk_be_i,
  output logic                       ld_hazard_o,
  output logic                       dc_req_o,
  input  logic                       dc_gnt_i,
  output logic [INDEX_W-1:0]         dc_index_o,
  output logic [63:0]                dc_wdata_o,
  output logic [7:0]                 dc_be_o,
  output logic [1:0]                 dc_size_o,
  output logic                       dc_we_o,
  output logic [TAG_W-1:0]           dc_tag_o,
  output logic                       dc_tag_valid_o,
  output logic                       dc_kill_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  stb_entry_t       mem [DEPTH];
  stb_entry_t       head, new_ent;
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [CNT_W-1:0] count, count_next;
  stb_state_t       state, state_next;
  logic             st_accept, push, pop, coal_hit;
  logic [DEPTH-1:0] ent_vld, ent_hit;
  logic             in_hit;
  logic             ld_idx_unused;

  assign head    = mem[head_ptr];
  assign new_ent = '{index: st_index_i, tag: st_tag_i, wdata: st_wdata_i,
                     be: st_be_i, size: st_size_i};

  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));
  assign count_o = count;

`ifdef LAGARTO_STB_COALESCE_EN
  logic [PTR_W-1:0] tail_idx;
  logic             tail_wm;

  assign tail_idx = tail_ptr - PTR_W'(1);

  // All-ones byte enables turn the comparator into a pure word match.
  lagarto_stb_word_match #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tail_match (
    .en     (1'b1),
    .word_a (mem[tail_idx].index[INDEX_W-1:3]),
    .tag_a  (mem[tail_idx].tag),
    .be_a   (8'hFF),
    .word_b (st_index_i[INDEX_W-1:3]),
    .tag_b  (st_tag_i),
    .be_b   (8'hFF),
    .hit    (tail_wm)
  );

  assign coal_hit   = st_valid_i & ~empty_o & tail_wm &
                      ((state == STB_IDLE) | (tail_idx != head_ptr));
  assign st_ready_o = ~full_o | coal_hit;
`else
  assign coal_hit   = 1'b0;
  assign st_ready_o = ~full_o;
`endif

  assign st_accept  = st_valid_i & st_ready_o;
  assign push       = st_accept & ~coal_hit;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      state    <= STB_IDLE;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      count <= count_next;
      state <= state_next;
    end
  end

  // Entry storage carries no reset; occupancy is defined solely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[tail_ptr] <= new_ent;
    end
`ifdef LAGARTO_STB_COALESCE_EN
    else if (coal_hit) begin
      mem[tail_idx].wdata <= stb_merge_bytes(mem[tail_idx].wdata, st_wdata_i, st_be_i);
      mem[tail_idx].be    <= mem[tail_idx].be | st_be_i;
      mem[tail_idx].size  <= 2'b11;
    end
`endif
  end

  // A store arriving into an empty buffer starts the index phase on the next cycle.
  always_comb begin
    state_next = state;
    case (state)
      STB_IDLE: if (!empty_o || push) state_next = STB_REQ;
      STB_REQ:  if (dc_gnt_i) state_next = STB_TAG;
      STB_TAG:  state_next = (count_next != '0) ? STB_REQ : STB_IDLE;
      default:  state_next = STB_IDLE;
    endcase
  end

  always_comb begin
    dc_req_o       = 1'b0;
    dc_tag_valid_o = 1'b0;
    pop            = 1'b0;
    case (state)
      STB_REQ: dc_req_o = 1'b1;
      STB_TAG: begin
        dc_tag_valid_o = 1'b1;
        pop            = 1'b1;
      end
      default: ;
    endcase
  end

  assign dc_we_o    = dc_req_o;
  assign dc_kill_o  = 1'b0;
  assign dc_index_o = dc_req_o ? head.index : '0;
  assign dc_wdata_o = dc_req_o ? head.wdata : '0;
  assign dc_be_o    = dc_req_o ? head.be    : '0;
  assign dc_size_o  = dc_req_o ? head.size  : '0;
  assign dc_tag_o   = dc_tag_valid_o ? head.tag : '0;

  // Slot i holds a live store when its distance from head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = CNT_W'(PTR_W'(i) - head_ptr) < count;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_hz
    lagarto_stb_word_match #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_match (
      .en     (ent_vld[g]),
      .word_a (mem[g].index[INDEX_W-1:3]),
      .tag_a  (mem[g].tag),
      .be_a   (mem[g].be),
      .word_b (ld_chk_index_i[INDEX_W-1:3]),
      .tag_b  (ld_chk_tag_i),
      .be_b   (ld_chk_be_i),
      .hit    (ent_hit[g])
    );
  end

  lagarto_stb_word_match #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_in_match (
    .en     (st_accept),
    .word_a (st_index_i[INDEX_W-1:3]),
    .tag_a  (st_tag_i),
    .be_a   (st_be_i),
    .word_b (ld_chk_index_i[INDEX_W-1:3]),
    .tag_b  (ld_chk_tag_i),
    .be_b   (ld_chk_be_i),
    .hit    (in_hit)
  );

  assign ld_hazard_o   = ld_chk_valid_i & ((|ent_hit) | in_hit);
  // Byte offset of the load is irrelevant; overlap is decided by byte enables.
  assign ld_idx_unused = ^ld_chk_index_i[2:0];

endmodule

// File: tb/tb_lagarto_store_buffer.sv
// Self-checking bench for lagarto_store_buffer: scoreboard of accepted stores checked
// against the index and tag phases, plus per-scenario directed checks.
module tb_lagarto_store_buffer;
  import drac_pkg::*;

  localparam int IW = DCACHE_INDEX_WIDTH;
  localparam int TW = DCACHE_TAG_WIDTH;

  logic          clk, rst;
  logic          st_valid, st_ready;
  logic [IW-1:0] st_index;
  logic [TW-1:0] st_tag;
  logic [63:0]   st_wdata;
  logic [7:0]    st_be;
  logic [1:0]    st_size;
  logic          ld_valid;
  logic [IW-1:0] ld_index;
  logic [TW-1:0] ld_tag;
  logic [7:0]    ld_be;
  logic          ld_hazard;
  logic          dc_req, dc_gnt, dc_we, dc_tag_valid, dc_kill;
  logic [IW-1:0] dc_index;
  logic [63:0]   dc_wdata;
  logic [7:0]    dc_be;
  logic [1:0]    dc_size;
  logic [TW-1:0] dc_tag;
  logic          empty, full;
  logic [2:0]    count;

  stb_entry_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

`ifdef LAGARTO_STB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lagarto_store_buffer #(.DEPTH(4), .INDEX_W(IW), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .st_valid_i(st_valid), .st_ready_o(st_ready), .st_index_i(st_index),
    .st_tag_i(st_tag), .st_wdata_i(st_wdata), .st_be_i(st_be), .st_size_i(st_size),
    .ld_chk_valid_i(ld_valid), .ld_chk_index_i(ld_index), .ld_chk_tag_i(ld_tag),
    .ld_chk_be_i(ld_be), .ld_hazard_o(ld_hazard),
    .dc_req_o(dc_req), .dc_gnt_i(dc_gnt), .dc_index_o(dc_index), .dc_wdata_o(dc_wdata),
    .dc_be_o(dc_be), .dc_size_o(dc_size), .dc_we_o(dc_we), .dc_tag_o(dc_tag),
    .dc_tag_valid_o(dc_tag_valid), .dc_kill_o(dc_kill),
    .empty_o(empty), .full_o(full), .count_o(count)
  );

  // Scoreboard: head of queue must match the index phase and the tag phase.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (dc_we !== dc_req || dc_kill !== 1'b0) begin
        n_fail++;
        $display("FAIL we_kill: we=%b kill=%b, required we=%b kill=0", dc_we, dc_kill, dc_req);
      end
      if (dc_req === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_req: unexpected request index=%h", dc_index);
        end else if ({dc_index, dc_wdata, dc_be, dc_size} !==
                     {q[0].index, q[0].wdata, q[0].be, q[0].size}) begin
          n_fail++;
          $display("FAIL sb_req: got idx=%h d=%h be=%h sz=%0d, required idx=%h d=%h be=%h sz=%0d",
                   dc_index, dc_wdata, dc_be, dc_size,
                   q[0].index, q[0].wdata, q[0].be, q[0].size);
        end
      end
      if (dc_tag_valid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_tag: unexpected tag phase tag=%h", dc_tag);
        end else begin
          if (dc_tag !== q[0].tag) begin
            n_fail++;
            $display("FAIL sb_tag: got tag=%h, required %h", dc_tag, q[0].tag);
          end
          void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [63:0] model_merge(input logic [63:0] o, input logic [63:0] n,
                                              input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic do_store(input logic [IW-1:0] idx, input logic [TW-1:0] tg,
                          input logic [63:0] d, input logic [7:0] be,
                          input logic [1:0] sz, input bit merge);
    int waited;
    stb_entry_t e;
    st_valid = 1'b1; st_index = idx; st_tag = tg; st_wdata = d; st_be = be; st_size = sz;
    waited = 0;
    @(negedge clk);
    while (st_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL store_accept: ready=%b, required 1", st_ready);
    end else if (merge && q.size() > 0) begin
      e = q[q.size()-1];
      e.wdata = model_merge(e.wdata, d, be);
      e.be    = e.be | be;
      e.size  = 2'b11;
      q[q.size()-1] = e;
    end else begin
      q.push_back('{index: idx, tag: tg, wdata: d, be: be, size: sz});
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (empty !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (empty !== 1'b1 || q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: empty=%b pending=%0d, required empty=1 pending=0", empty, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({count, empty, full, st_ready, dc_req, dc_tag_valid, ld_hazard} !== {3'd0, 6'b101000}) begin
      n_fail++;
      $display("FAIL reset: cnt=%0d empty=%b full=%b rdy=%b req=%b tv=%b hz=%b, required 0 1 0 1 0 0 0",
               count, empty, full, st_ready, dc_req, dc_tag_valid, ld_hazard);
    end
    n_cmp++;
    if ({dc_index, dc_wdata, dc_be, dc_size, dc_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: idx=%h d=%h be=%h tag=%h, required 0", dc_index, dc_wdata, dc_be, dc_tag);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    dc_gnt = 1'b1;
    @(posedge clk); #1;
    do_store(12'h128, 26'h5, 64'h1122334455667788, 8'h0F, 2'd2, 1'b0);
    n_cmp++;
    if (dc_req !== 1'b1) begin
      n_fail++;
      $display("FAIL single_req: req=%b at N+1, required 1", dc_req);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dc_tag_valid !== 1'b1 || dc_tag !== 26'h5) begin
      n_fail++;
      $display("FAIL single_tag: tv=%b tag=%h at N+2, required 1 5", dc_tag_valid, dc_tag);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (empty !== 1'b1 || dc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty: empty=%b req=%b at N+3, required 1 0", empty, dc_req);
    end
  endtask

  task automatic test_hazard();
    dc_gnt = 1'b0;
    @(posedge clk); #1;
    st_valid = 1'b1; st_index = 12'h128; st_tag = 26'h5; st_wdata = 64'hA5A5A5A5_5A5A5A5A;
    st_be = 8'h0F; st_size = 2'd2;
    ld_valid = 1'b1; ld_index = 12'h12C; ld_tag = 26'h5; ld_be = 8'h08;
    #1;
    n_cmp++;
    if (ld_hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hz_incoming: hazard=%b, required 1", ld_hazard);
    end
    @(negedge clk);
    q.push_back('{index: st_index, tag: st_tag, wdata: st_wdata, be: st_be, size: st_size});
    @(posedge clk); #1;
    st_valid = 1'b0;
    ld_be = 8'hF0; #1;
    n_cmp++;
    if (ld_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hz_disjoint_be: hazard=%b, required 0", ld_hazard);
    end
    ld_be = 8'h18; #1;
    n_cmp++;
    if (ld_hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hz_overlap: hazard=%b, required 1", ld_hazard);
    end
    ld_tag = 26'h6; #1;
    n_cmp++;
    if (ld_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hz_other_tag: hazard=%b, required 0", ld_hazard);
    end
    ld_tag = 26'h5; ld_index = 12'h130; #1;
    n_cmp++;
    if (ld_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hz_other_word: hazard=%b, required 0", ld_hazard);
    end
    ld_index = 12'h12C; ld_valid = 1'b0; #1;
    n_cmp++;
    if (ld_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hz_chk_invalid: hazard=%b, required 0", ld_hazard);
    end
    dc_gnt = 1'b1;
    wait_empty();
    ld_valid = 1'b1; #1;
    n_cmp++;
    if (ld_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL hz_after_drain: hazard=%b, required 0", ld_hazard);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_back_to_back_full();
    dc_gnt = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      do_store(IW'(12'h100 + i*8), TW'(26'h10 + i), {$urandom, $urandom}, 8'hFF >> i, 2'd3, 1'b0);
    end
    n_cmp++;
    if (full !== 1'b1 || st_ready !== 1'b0 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL full: full=%b rdy=%b cnt=%0d, required 1 0 4", full, st_ready, count);
    end
    st_valid = 1'b1; st_index = 12'h180; st_tag = 26'h44; st_be = 8'h01;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (st_ready !== 1'b0 || count !== 3'd4) begin
        n_fail++;
        $display("FAIL stall: rdy=%b cnt=%0d, required 0 4", st_ready, count);
      end
    end
    @(posedge clk); #1;
    dc_gnt = 1'b1;
    do_store(12'h180, 26'h44, 64'hDEADBEEF_0BADF00D, 8'h01, 2'd0, 1'b0);
    wait_empty();
  endtask

  task automatic test_enq_during_tag();
    dc_gnt = 1'b1;
    @(posedge clk); #1;
    do_store(12'h040, 26'h21, 64'h0123456789ABCDEF, 8'hF0, 2'd2, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (dc_tag_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL tag_phase: tv=%b, required 1", dc_tag_valid);
    end
    do_store(12'h088, 26'h22, 64'hFEDCBA9876543210, 8'h3C, 2'd2, 1'b0);
    n_cmp++;
    if (count !== 3'd1 || dc_req !== 1'b1 || dc_index !== 12'h088) begin
      n_fail++;
      $display("FAIL enq_tag: cnt=%0d req=%b idx=%h, required 1 1 088", count, dc_req, dc_index);
    end
    wait_empty();
  endtask

  task automatic test_reset_mid();
    dc_gnt = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      do_store(IW'(12'h200 + i*16), TW'(26'h30 + i), {$urandom, $urandom}, 8'h0F, 2'd2, 1'b0);
    end
    n_cmp++;
    if (dc_req !== 1'b1 || count !== 3'd3) begin
      n_fail++;
      $display("FAIL pre_rst: req=%b cnt=%0d, required 1 3", dc_req, count);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dc_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst: req=%b cnt=%0d empty=%b rdy=%b, required 0 0 1 1",
               dc_req, count, empty, st_ready);
    end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    dc_gnt = 1'b1;
    do_store(12'h3F8, 26'h3FF, 64'h5555AAAA5555AAAA, 8'h80, 2'd0, 1'b0);
    wait_empty();
  endtask

  task automatic test_coalesce();
    dc_gnt = 1'b0;
    @(posedge clk); #1;
    do_store(12'h300, 26'h9, 64'h1111111111111111, 8'hFF, 2'd3, 1'b0);
    do_store(12'h200, 26'h7, 64'h00000000_0000BBAA, 8'h03, 2'd1, 1'b0);
    do_store(12'h204, 26'h7, 64'h00000000_DDCC0000, 8'h0C, 2'd1, COAL);
    n_cmp++;
    if (count !== (COAL ? 3'd2 : 3'd3)) begin
      n_fail++;
      $display("FAIL coalesce_cnt: cnt=%0d, required %0d", count, COAL ? 2 : 3);
    end
    dc_gnt = 1'b1;
    wait_empty();
  endtask

  initial begin
    st_valid = 1'b0; st_index = '0; st_tag = '0; st_wdata = '0; st_be = '0; st_size = '0;
    ld_valid = 1'b0; ld_index = '0; ld_tag = '0; ld_be = '0; dc_gnt = 1'b0;
    test_reset();
    test_single();
    test_hazard();
    test_back_to_back_full();
    test_enq_during_tag();
    test_reset_mid();
    test_coalesce();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
